// File: rtl/fp16_mantissa_divider.sv
// Mantissa stage of the FP16 divider: accepts sign/exponent from the
// sign/exponent summator, runs a 12-step restoring division of the 11-bit
// significands, normalizes, and packs the FP16 quotient.
//
// Ports:
//   clk        system clock, rising edge
//   res        synchronous active-high reset
//   load       level strobe from summator; sign/exponent valid while high
//   sign       result sign from summator
//   exponent   biased result exponent from summator
//   divisible  FP16 dividend
//   divider    FP16 divisor
//   result     packed FP16 quotient (registered)
//   ready      result valid; handshake back to summator (registered)
//   busy       high while dividing or normalizing (registered)
module fp16_mantissa_divider #(
    parameter int unsigned MANT_W = 10,
    parameter int unsigned EXP_W  = 5
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      load,
    input  logic                      sign,
    input  logic [EXP_W-1:0]          exponent,
    input  logic [EXP_W+MANT_W:0]     divisible,
    input  logic [EXP_W+MANT_W:0]     divider,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      ready,
    output logic                      busy
);

    localparam int unsigned SIG_W  = MANT_W + 1;  // significand with hidden 1
    localparam int unsigned REM_W  = MANT_W + 2;  // remainder / quotient width
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 1 + EXP_W + MANT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [REM_W-1:0]   rem;
    logic [REM_W-1:0]   q;
    logic [CNT_W-1:0]   cnt;
    logic [SIG_W-1:0]   mb;
    logic               sign_q;
    logic [EXP_W-1:0]   exp_q;
    logic               dz;
    logic               nz;

    // Restoring-division step: trial subtract and next remainder.
    logic               ge_c;
    logic [REM_W-1:0]   diff_c;
    logic [REM_W-1:0]   rem_next_c;

    always_comb begin
        ge_c       = (rem >= REM_W'(mb));
        diff_c     = rem - REM_W'(mb);
        rem_next_c = ge_c ? {diff_c[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};
    end

    // Normalization and packing, including the zero-operand overrides.
    logic [MANT_W-1:0]  mant_c;
    logic [EXP_W-1:0]   exp_c;
    logic [WORD_W-1:0]  packed_c;

    always_comb begin
        if (q[REM_W-1]) begin
            mant_c = q[MANT_W:1];
            exp_c  = exp_q;
        end else begin
            mant_c = q[MANT_W-1:0];
            exp_c  = exp_q - EXP_W'(1);
        end
        if (dz)
            packed_c = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (nz)
            packed_c = {sign_q, {(EXP_W+MANT_W){1'b0}}};
        else
            packed_c = {sign_q, exp_c, mant_c};
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state  <= IDLE;
            result <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            mb     <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            dz     <= 1'b0;
            nz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sign_q <= sign;
                        exp_q  <= exponent;
                        mb     <= {1'b1, divider[MANT_W-1:0]};
                        rem    <= REM_W'({1'b1, divisible[MANT_W-1:0]});
                        dz     <= (divider[WORD_W-2:0] == '0);
                        nz     <= (divisible[WORD_W-2:0] == '0);
                        q      <= '0;
                        cnt    <= CNT_W'(REM_W - 1);
                        busy   <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_next_c;
                    if (ge_c)
                        q[cnt] <= 1'b1;
                    if (cnt == '0)
                        state <= NORM;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                NORM: begin
                    result <= packed_c;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    // ready is raised for at least one cycle, then held until
                    // the summator drops load.
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (!load) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
